// File: rtl/divider_output_stage.sv
// Final stage of the pipelined divider: forms quotient/remainder/status from
// the last slice and presents them through a 2-entry valid/ready skid buffer.
module divider_output_stage #(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int COUNTW      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_in,
  output logic                                 ready_out,
  input  logic [DIVIDENDLEN+DIVISORLEN-2:0]    din,
  input  logic [DIVISORLEN-1:0]                divin,
  input  logic [DIVIDENDLEN-1:0]               qin,
  output logic                                 valid_out,
  input  logic                                 ready_in,
  output logic [DIVIDENDLEN-1:0]               quotient,
  output logic [DIVISORLEN-1:0]                remainder,
  output logic                                 divzero,
  output logic                                 rem_err,
  output logic [COUNTW-1:0]                    done_count
);

  localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;

  typedef struct packed {
    logic [DIVIDENDLEN-1:0] quo;
    logic [DIVISORLEN-1:0]  rem;
    logic                   dz;
    logic                   err;
  } res_t;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t state, next_state;
  res_t   fresh, m_q, s_q;
  logic   accept, emit;
  logic   load_m, load_s, m_from_s;

  assign accept = valid_in & ready_out;
  assign emit   = valid_out & ready_in;

  // Result formation from the last slice; a zero divisor saturates the
  // quotient and masks the upper-remainder fault check.
  always_comb begin
    fresh     = '0;
    fresh.dz  = (divin == '0);
    fresh.quo = fresh.dz ? '1 : qin;
    fresh.rem = din[DIVISORLEN-1:0];
    fresh.err = !fresh.dz & (|din[DATAPATHLEN-1:DIVISORLEN]);
  end

  // Skid-buffer next-state and register-load decode.
  always_comb begin
    next_state = state;
    load_m     = 1'b0;
    load_s     = 1'b0;
    m_from_s   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_m     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (accept && emit) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s     = 1'b1;
          next_state = FULL;
        end else if (emit) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          m_from_s   = 1'b1;
          next_state = BUSY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // State, storage, registered ready and delivered-result counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      ready_out  <= 1'b0;
      m_q        <= '0;
      s_q        <= '0;
      done_count <= '0;
    end else begin
      state     <= next_state;
      ready_out <= (next_state != FULL);
      if (load_m)        m_q <= fresh;
      else if (m_from_s) m_q <= s_q;
      if (load_s)        s_q <= fresh;
      if (emit)          done_count <= done_count + COUNTW'(1);
    end
  end

  assign valid_out = (state != EMPTY);
  assign quotient  = m_q.quo;
  assign remainder = m_q.rem;
  assign divzero   = m_q.dz;
  assign rem_err   = m_q.err;

endmodule

// File: tb/tb_divider_output_stage.sv
// Directed bench for divider_output_stage: inputs driven and outputs sampled
// on the falling edge, expected values hand-computed.
module tb_divider_output_stage;

  localparam int DIVIDENDLEN = 16;
  localparam int DIVISORLEN  = 8;
  localparam int COUNTW      = 8;
  localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   valid_in;
  logic                   ready_out;
  logic [DATAPATHLEN-1:0] din;
  logic [DIVISORLEN-1:0]  divin;
  logic [DIVIDENDLEN-1:0] qin;
  logic                   valid_out;
  logic                   ready_in;
  logic [DIVIDENDLEN-1:0] quotient;
  logic [DIVISORLEN-1:0]  remainder;
  logic                   divzero;
  logic                   rem_err;
  logic [COUNTW-1:0]      done_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divider_output_stage #(
    .DIVIDENDLEN(DIVIDENDLEN), .DIVISORLEN(DIVISORLEN), .COUNTW(COUNTW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .din(din), .divin(divin), .qin(qin), .valid_out(valid_out),
    .ready_in(ready_in), .quotient(quotient), .remainder(remainder),
    .divzero(divzero), .rem_err(rem_err), .done_count(done_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    din = '0; divin = '0; qin = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_ready", 32'(ready_out), 0);
    chk("rst_quot",  32'(quotient), 0);
    chk("rst_rem",   32'(remainder), 0);
    chk("rst_dz",    32'(divzero), 0);
    chk("rst_err",   32'(rem_err), 0);
    chk("rst_count", 32'(done_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(ready_out), 1);
    chk("idle_valid", 32'(valid_out), 0);

    // basic 1000/7 = 142 r 6
    din = 23'd6; divin = 8'd7; qin = 16'd142; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("basic_valid", 32'(valid_out), 1);
    chk("basic_quot",  32'(quotient), 142);
    chk("basic_rem",   32'(remainder), 6);
    chk("basic_dz",    32'(divzero), 0);
    chk("basic_err",   32'(rem_err), 0);
    @(negedge clk);
    chk("basic_count", 32'(done_count), 1);
    chk("basic_drain", 32'(valid_out), 0);

    // backpressure: A then B fill the stage, a third push is ignored
    ready_in = 1'b0;
    valid_in = 1'b1; din = 23'h11; divin = 8'd1; qin = 16'd1;
    @(negedge clk);
    chk("bp_a_ready", 32'(ready_out), 1);
    din = 23'h22; qin = 16'd2;
    @(negedge clk);
    chk("bp_full_ready", 32'(ready_out), 0);
    chk("bp_full_valid", 32'(valid_out), 1);
    chk("bp_hold_quot",  32'(quotient), 1);
    din = 23'h33; qin = 16'd3;
    @(negedge clk);
    chk("bp_ign_quot",  32'(quotient), 1);
    chk("bp_ign_rem",   32'(remainder), 'h11);
    chk("bp_ign_count", 32'(done_count), 1);
    valid_in = 1'b0; ready_in = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", 32'(valid_out), 1);
    chk("bp_b_quot",  32'(quotient), 2);
    chk("bp_b_rem",   32'(remainder), 'h22);
    chk("bp_b_ready", 32'(ready_out), 1);
    @(negedge clk);
    chk("bp_empty", 32'(valid_out), 0);
    chk("bp_count", 32'(done_count), 3);
    @(negedge clk);
    chk("bp_no_third", 32'(valid_out), 0);
    chk("bp_idle_cnt", 32'(done_count), 3);

    // divide by zero, then upper-remainder fault back to back
    valid_in = 1'b1; din = 23'h00ABCD; divin = 8'd0; qin = 16'd5;
    @(negedge clk);
    din = 23'h000105; divin = 8'd3; qin = 16'h57;
    chk("dz_valid", 32'(valid_out), 1);
    chk("dz_flag",  32'(divzero), 1);
    chk("dz_quot",  32'(quotient), 'hFFFF);
    chk("dz_rem",   32'(remainder), 'hCD);
    chk("dz_err",   32'(rem_err), 0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("flt_err",  32'(rem_err), 1);
    chk("flt_rem",  32'(remainder), 5);
    chk("flt_dz",   32'(divzero), 0);
    chk("flt_quot", 32'(quotient), 'h57);
    @(negedge clk);
    chk("flt_count", 32'(done_count), 5);

    // clear the counter, then stream 300 results
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("st_pre_count", 32'(done_count), 0);
    divin = 8'd1; ready_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      valid_in = 1'b1; qin = 16'(i); din = 23'(i % 200);
      @(negedge clk);
      chk("st_valid", 32'(valid_out), 1);
      chk("st_quot",  32'(quotient), 32'(i));
      chk("st_count", 32'(done_count), 32'(i % 256));
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("st_final_count", 32'(done_count), 44);
    chk("st_final_valid", 32'(valid_out), 0);

    // reset while FULL discards both entries
    ready_in = 1'b0; valid_in = 1'b1; divin = 8'd9;
    qin = 16'hA; din = 23'h1;
    @(negedge clk);
    qin = 16'hB; din = 23'h2;
    @(negedge clk);
    chk("mr_full", 32'(ready_out), 0);
    valid_in = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", 32'(valid_out), 0);
    chk("mr_ready", 32'(ready_out), 0);
    chk("mr_count", 32'(done_count), 0);
    chk("mr_quot",  32'(quotient), 0);
    reset = 1'b0; ready_in = 1'b1;
    @(negedge clk);
    chk("mr_ready_up", 32'(ready_out), 1);
    chk("mr_no_emit",  32'(valid_out), 0);
    @(negedge clk);
    chk("mr_still_empty", 32'(valid_out), 0);
    chk("mr_no_count",    32'(done_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
